// File: rtl/lsu_mem_access_if.sv
// Bus channel between the load/store unit and the data memory: one request
// phase (valid/ready) followed by one response beat carrying read data or a write ack.
interface lsu_mem_access_if;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        req_we_o;
    logic [63:0] req_addr_o;
    logic [63:0] req_wdata_o;
    logic [7:0]  req_wstrb_o;
    logic        resp_valid_i;
    logic [63:0] resp_rdata_i;

    modport master (
        output req_valid_o,
        output req_we_o,
        output req_addr_o,
        output req_wdata_o,
        output req_wstrb_o,
        input  req_ready_i,
        input  resp_valid_i,
        input  resp_rdata_i
    );

    modport slave (
        input  req_valid_o,
        input  req_we_o,
        input  req_addr_o,
        input  req_wdata_o,
        input  req_wstrb_o,
        output req_ready_i,
        output resp_valid_i,
        output resp_rdata_i
    );
endinterface

// File: rtl/lsu_mem_access.sv
// MEM-stage load/store unit: turns an aligned load/store into one bus
// transaction, stalls the pipeline while it runs, and formats load data for writeback.
module lsu_mem_access (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_i,
    input  logic                      store_i,
    input  logic [2:0]                funct3_i,
    input  logic [63:0]               aluout_i,
    input  logic [63:0]               sdata_i,
    input  logic                      wen_i,
    input  logic [4:0]                rd_i,
    output logic                      stall_o,
    output logic                      misalign_o,
    output logic                      wen_o,
    output logic [4:0]                rd_o,
    output logic [63:0]               wdata_o,
    lsu_mem_access_if.master          bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;

    logic [63:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        store_q;
    logic [63:0] sdata_q;
    logic        wen_q;
    logic [4:0]  rd_q;
    logic [63:0] result_q;

    logic        access;
    logic [2:0]  low_mask;
    logic        misaligned;
    logic        start;
    logic [63:0] rdata_shifted;
    logic [63:0] load_result;
    logic [7:0]  size_strb;

    // Decode of the incoming MEM-stage instruction.
    assign access = load_i | store_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        low_mask = 3'b000;
        case (funct3_i[1:0])
            2'd0:    low_mask = 3'b000;
            2'd1:    low_mask = 3'b001;
            2'd2:    low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
    end

    assign misaligned = access && ((aluout_i[2:0] & low_mask) != 3'b000);
    assign start      = (state_q == IDLE) && access && !misaligned;

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)            state_d = REQ;
            REQ:     if (bus.req_ready_i)  state_d = WAIT;
            WAIT:    if (bus.resp_valid_i) state_d = DONE;
            DONE:                          state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Extract the addressed bytes from the aligned doubleword and extend to 64 bits.
    assign rdata_shifted = bus.resp_rdata_i >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_result = 64'd0;
        case (size_q)
            2'd0: load_result = unsigned_q ? {56'd0, rdata_shifted[7:0]}
                                           : {{56{rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'd1: load_result = unsigned_q ? {48'd0, rdata_shifted[15:0]}
                                           : {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            2'd2: load_result = unsigned_q ? {32'd0, rdata_shifted[31:0]}
                                           : {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            default: load_result = rdata_shifted;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: capture registers are reset so a reset mid-access leaves no stale request or result behind.
        if (reset) begin
            addr_q     <= 64'd0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            store_q    <= 1'b0;
            sdata_q    <= 64'd0;
            wen_q      <= 1'b0;
            rd_q       <= 5'd0;
            result_q   <= 64'd0;
        end else begin
            if (start) begin
                addr_q     <= aluout_i;
                size_q     <= funct3_i[1:0];
                unsigned_q <= funct3_i[2];
                store_q    <= store_i;
                sdata_q    <= sdata_i;
                wen_q      <= wen_i & ~store_i;
                rd_q       <= rd_i;
            end
            if ((state_q == WAIT) && bus.resp_valid_i) begin
                result_q <= load_result;
            end
        end
    end

    always_comb begin
        size_strb = 8'h00;
        case (size_q)
            2'd0:    size_strb = 8'h01;
            2'd1:    size_strb = 8'h03;
            2'd2:    size_strb = 8'h0F;
            default: size_strb = 8'hFF;
        endcase
    end

    // Request fields come only from capture registers, so they hold steady while REQ waits on ready.
    always_comb begin
        bus.req_valid_o = (state_q == REQ);
        bus.req_we_o    = store_q;
        bus.req_addr_o  = {addr_q[63:3], 3'b000};
        bus.req_wdata_o = sdata_q << {addr_q[2:0], 3'b000};
        bus.req_wstrb_o = store_q ? (size_strb << addr_q[2:0]) : 8'h00;
    end

    always_comb begin
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        wen_o      = 1'b0;
        rd_o       = rd_q;
        wdata_o    = 64'd0;
        case (state_q)
            IDLE: begin
                misalign_o = misaligned;
                stall_o    = start;
                wen_o      = access ? 1'b0 : wen_i;
                rd_o       = rd_i;
                wdata_o    = aluout_i;
            end
            REQ, WAIT: begin
                stall_o = 1'b1;
            end
            DONE: begin
                wen_o   = wen_q;
                rd_o    = rd_q;
                wdata_o = result_q;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

endmodule
